// File: rtl/rsb_ckpt_if.sv
// ---------------------------------------------------------------------------
// rsb_ckpt_if : fetch-side bundle for the return-address stack predictor.
//
// Carries the per-slot decode info of one fetch bundle, the repair request
// from the commit/branch unit and the predictor's outputs (prediction,
// checkpoint export and overflow/underflow pulses).
//
//   master : fetch/commit side, drives slot info and restore, reads results
//   slave  : the predictor (rsb_ckpt)
// ---------------------------------------------------------------------------
interface rsb_ckpt_if #(
    parameter int AMSB   = 79,
    parameter int QSLOTS = 3,
    parameter int PW     = 4
);
    logic [5:0]              regLR;
    logic [QSLOTS-1:0]       queuedOn;
    logic [QSLOTS-1:0]       jal;
    logic [QSLOTS-1:0]       call;
    logic [QSLOTS-1:0]       ret;
    logic [QSLOTS-1:0][6:0]  Ra;
    logic [QSLOTS-1:0][6:0]  Rd;
    logic [AMSB:0]           ip;

    logic                    restore;
    logic [PW-1:0]           restore_ptr;
    logic [PW:0]             restore_cnt;
    logic [AMSB:0]           restore_top;

    logic [AMSB:0]           ra;
    logic                    ra_valid;
    logic                    ckpt_vld;
    logic [1:0]              ckpt_slot;
    logic [PW-1:0]           ckpt_ptr;
    logic [PW:0]             ckpt_cnt;
    logic [AMSB:0]           ckpt_top;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output regLR, queuedOn, jal, call, ret, Ra, Rd, ip,
        output restore, restore_ptr, restore_cnt, restore_top,
        input  ra, ra_valid, ckpt_vld, ckpt_slot, ckpt_ptr, ckpt_cnt,
        input  ckpt_top, overflow, underflow
    );

    modport slave (
        input  regLR, queuedOn, jal, call, ret, Ra, Rd, ip,
        input  restore, restore_ptr, restore_cnt, restore_top,
        output ra, ra_valid, ckpt_vld, ckpt_slot, ckpt_ptr, ckpt_cnt,
        output ckpt_top, overflow, underflow
    );
endinterface

// File: rtl/rsb_ckpt.sv
// ---------------------------------------------------------------------------
// rsb_ckpt : return-address stack predictor with checkpoint/restore.
//
// Updated at fetch time. Of the QSLOTS queued instructions in a bundle, the
// lowest slot that touches the stack acts: calls / link JALs push the return
// address, returns / link-source JALs pop, a JAL that does both swaps the
// top. Each acting update exports the pre-update pointer, occupancy and top
// entry so the commit/branch unit can repair the stack exactly later.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous active-low reset
//   bus  - rsb_ckpt_if.slave
//          in : regLR, queuedOn, jal, call, ret, Ra, Rd, ip,
//               restore, restore_ptr, restore_cnt, restore_top
//          out: ra, ra_valid (combinational from current state)
//               ckpt_vld, ckpt_slot, ckpt_ptr, ckpt_cnt, ckpt_top,
//               overflow, underflow (registered, one-cycle)
// ---------------------------------------------------------------------------
module rsb_ckpt #(
    parameter int            AMSB   = 79,
    parameter int            DEPTH  = 16,
    parameter int            QSLOTS = 3,
    parameter logic [AMSB:0] RSTPC  = 80'hFFFFFFFFFFFFFFFC0100,
    localparam int           PW     = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    rsb_ckpt_if.slave  bus
);

    logic [AMSB:0]   ras [DEPTH];
    logic [PW-1:0]   rasp;
    logic [PW:0]     count;

    logic            ckpt_vld_q;
    logic [1:0]      ckpt_slot_q;
    logic [PW-1:0]   ckpt_ptr_q;
    logic [PW:0]     ckpt_cnt_q;
    logic [AMSB:0]   ckpt_top_q;
    logic            overflow_q;
    logic            underflow_q;

    logic [QSLOTS-1:0] slot_push;
    logic [QSLOTS-1:0] slot_pop;
    logic [AMSB:0]     slot_addr [QSLOTS];

    logic              act;
    logic [1:0]        act_slot;
    logic              act_push;
    logic              act_pop;
    logic [AMSB:0]     act_addr;

    logic [AMSB-4:0]   ip_hi;
    logic [AMSB-4:0]   ip_hi_inc;

    // Low nibble of ip and register-number bit 6 carry no stack meaning.
    logic              unused_bits;
    assign unused_bits = ^{bus.ip[3:0], bus.Ra, bus.Rd};

    assign ip_hi     = bus.ip[AMSB:4];
    // Carry out of AMSB is dropped: a bundle at the top of the address
    // space returns to address zero.
    assign ip_hi_inc = ip_hi + (AMSB-3)'(1);

    always_comb begin
        for (int s = 0; s < QSLOTS; s++) begin
            slot_push[s] = bus.queuedOn[s] &
                           (bus.call[s] | (bus.jal[s] & (bus.Rd[s][5:0] == bus.regLR)));
            slot_pop[s]  = bus.queuedOn[s] &
                           (bus.ret[s]  | (bus.jal[s] & (bus.Ra[s][5:0] == bus.regLR)));
            // Inner slots return into the same 16-byte bundle; the last
            // slot's return address is the start of the next bundle.
            if (s == QSLOTS - 1)
                slot_addr[s] = {ip_hi_inc, 4'h0};
            else
                slot_addr[s] = {ip_hi, 4'(5 * (s + 1))};
        end
    end

    // Lowest modifying slot wins: fetch redirects on it, so anything after
    // it in the bundle is on the wrong path.
    always_comb begin
        act      = 1'b0;
        act_slot = 2'd0;
        act_push = 1'b0;
        act_pop  = 1'b0;
        act_addr = '0;
        for (int s = 0; s < QSLOTS; s++) begin
            if (!act && (slot_push[s] | slot_pop[s])) begin
                act      = 1'b1;
                act_slot = 2'(s);
                act_push = slot_push[s];
                act_pop  = slot_pop[s];
                act_addr = slot_addr[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                ras[i] <= RSTPC;
            rasp        <= '0;
            count       <= '0;
            ckpt_vld_q  <= 1'b0;
            ckpt_slot_q <= 2'd0;
            ckpt_ptr_q  <= '0;
            ckpt_cnt_q  <= '0;
            ckpt_top_q  <= RSTPC;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            ckpt_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            if (bus.restore) begin
                rasp                  <= bus.restore_ptr;
                count                 <= bus.restore_cnt;
                ras[bus.restore_ptr]  <= bus.restore_top;
            end else if (act) begin
                ckpt_vld_q  <= 1'b1;
                ckpt_slot_q <= act_slot;
                ckpt_ptr_q  <= rasp;
                ckpt_cnt_q  <= count;
                ckpt_top_q  <= ras[rasp];
                if (act_push && act_pop) begin
                    ras[rasp] <= act_addr;
                end else if (act_push) begin
                    // When full the write wraps onto the oldest entry.
                    ras[rasp - PW'(1)] <= act_addr;
                    rasp               <= rasp - PW'(1);
                    if (count == (PW+1)'(DEPTH))
                        overflow_q <= 1'b1;
                    else
                        count <= count + (PW+1)'(1);
                end else begin
                    if (count != '0) begin
                        rasp  <= rasp + PW'(1);
                        count <= count - (PW+1)'(1);
                    end else begin
                        underflow_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ra        = ras[rasp];
    assign bus.ra_valid  = (count != '0);
    assign bus.ckpt_vld  = ckpt_vld_q;
    assign bus.ckpt_slot = ckpt_slot_q;
    assign bus.ckpt_ptr  = ckpt_ptr_q;
    assign bus.ckpt_cnt  = ckpt_cnt_q;
    assign bus.ckpt_top  = ckpt_top_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_rsb_ckpt.sv
// ---------------------------------------------------------------------------
// tb_rsb_ckpt : scoreboard bench for rsb_ckpt.
//
// The driver applies one bundle per cycle on the falling edge, advances a
// circular-buffer reference model and queues the expected post-edge outputs.
// A separate monitor pops one expectation after each rising edge and checks
// it. Directed scenarios add literal checks of key values.
// ---------------------------------------------------------------------------
module tb_rsb_ckpt;
    localparam int            AMSB   = 79;
    localparam int            DEPTH  = 16;
    localparam int            QS     = 3;
    localparam int            PW     = 4;
    localparam logic [79:0]   RSTPC  = 80'hFFFFFFFFFFFFFFFC0100;

    typedef struct {
        logic [79:0] ra;
        logic        rav;
        logic        vld;
        int          slot;
        int          ptr;
        int          cnt;
        logic [79:0] top;
        logic        ovf;
        logic        unf;
    } exp_t;

    typedef struct {
        int          ptr;
        int          cnt;
        logic [79:0] top;
    } ck_t;

    logic clk;
    logic rst;
    rsb_ckpt_if #(.AMSB(AMSB), .QSLOTS(QS), .PW(PW)) bus ();

    rsb_ckpt #(.AMSB(AMSB), .DEPTH(DEPTH), .QSLOTS(QS), .RSTPC(RSTPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    exp_t        sb [$];
    ck_t         ck_q [$];
    logic [79:0] mem [DEPTH];
    int          mp;
    int          mc;
    exp_t        last_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = RSTPC;
        mp = 0;
        mc = 0;
        ck_q.delete();
    endtask

    task automatic idle();
        bus.queuedOn    = '0;
        bus.jal         = '0;
        bus.call        = '0;
        bus.ret         = '0;
        bus.Ra          = '0;
        bus.Rd          = '0;
        bus.ip          = '0;
        bus.restore     = 1'b0;
        bus.restore_ptr = '0;
        bus.restore_cnt = '0;
        bus.restore_top = '0;
    endtask

    // Reference: stack is a circular array indexed by a growing-downward top
    // pointer; all arithmetic is plain modular integer math.
    task automatic apply();
        exp_t        e;
        bit          found;
        int          fs;
        bit          fpu, fpo;
        logic [79:0] base, addr;
        found = 0; fs = 0; fpu = 0; fpo = 0;
        e.vld = 0; e.ovf = 0; e.unf = 0; e.slot = 0; e.ptr = 0; e.cnt = 0; e.top = '0;
        if (bus.restore) begin
            mp = int'(bus.restore_ptr);
            mc = int'(bus.restore_cnt);
            mem[mp] = bus.restore_top;
        end else begin
            for (int s = 0; s < QS; s++) begin
                bit pu, po;
                pu = bus.queuedOn[s] && (bus.call[s] || (bus.jal[s] && bus.Rd[s][5:0] == bus.regLR));
                po = bus.queuedOn[s] && (bus.ret[s]  || (bus.jal[s] && bus.Ra[s][5:0] == bus.regLR));
                if (!found && (pu || po)) begin
                    found = 1; fs = s; fpu = pu; fpo = po;
                end
            end
            if (found) begin
                base = {bus.ip[79:4], 4'h0};
                addr = (fs == QS - 1) ? base + 80'd16 : base + 80'(5 * (fs + 1));
                e.vld = 1; e.slot = fs; e.ptr = mp; e.cnt = mc; e.top = mem[mp];
                ck_q.push_back('{ptr: mp, cnt: mc, top: mem[mp]});
                if (ck_q.size() > 8) void'(ck_q.pop_front());
                if (fpu && fpo) begin
                    mem[mp] = addr;
                end else if (fpu) begin
                    mp = (mp + DEPTH - 1) % DEPTH;
                    mem[mp] = addr;
                    if (mc == DEPTH) e.ovf = 1;
                    else mc++;
                end else begin
                    if (mc > 0) begin
                        mp = (mp + 1) % DEPTH;
                        mc--;
                    end else begin
                        e.unf = 1;
                    end
                end
            end
        end
        e.ra  = mem[mp];
        e.rav = (mc != 0);
        last_e = e;
        sb.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && sb.size() > 0) begin
                e = sb.pop_front();
                chk("ra",        bus.ra,              e.ra);
                chk("ra_valid",  80'(bus.ra_valid),   80'(e.rav));
                chk("ckpt_vld",  80'(bus.ckpt_vld),   80'(e.vld));
                chk("overflow",  80'(bus.overflow),   80'(e.ovf));
                chk("underflow", 80'(bus.underflow),  80'(e.unf));
                if (e.vld) begin
                    chk("ckpt_slot", 80'(bus.ckpt_slot), 80'(e.slot));
                    chk("ckpt_ptr",  80'(bus.ckpt_ptr),  80'(e.ptr));
                    chk("ckpt_cnt",  80'(bus.ckpt_cnt),  80'(e.cnt));
                    chk("ckpt_top",  bus.ckpt_top,       e.top);
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        sb.delete();
        chk("rst_ra",        bus.ra,               RSTPC);
        chk("rst_ra_valid",  80'(bus.ra_valid),    80'(0));
        chk("rst_ckpt_vld",  80'(bus.ckpt_vld),    80'(0));
        chk("rst_overflow",  80'(bus.overflow),    80'(0));
        chk("rst_underflow", 80'(bus.underflow),   80'(0));
        chk("rst_ckpt_top",  bus.ckpt_top,         RSTPC);
        chk("rst_ckpt_ptr",  80'(bus.ckpt_ptr),    80'(0));
        chk("rst_ckpt_cnt",  80'(bus.ckpt_cnt),    80'(0));
        idle();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_slot(int s, bit c, bit r, bit j, logic [6:0] ra_r, logic [6:0] rd_r);
        bus.queuedOn[s] = 1'b1;
        bus.call[s]     = c;
        bus.ret[s]      = r;
        bus.jal[s]      = j;
        bus.Ra[s]       = ra_r;
        bus.Rd[s]       = rd_r;
    endtask

    task automatic one_call(int s, logic [79:0] ipv);
        @(negedge clk);
        idle();
        bus.ip = ipv;
        set_slot(s, 1, 0, 0, 7'd0, 7'd0);
        apply();
    endtask

    task automatic one_ret(int s);
        @(negedge clk);
        idle();
        set_slot(s, 0, 1, 0, 7'd0, 7'd0);
        apply();
    endtask

    task automatic post();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ck_t ck;
        rst = 1'b0;
        bus.regLR = 6'd61;
        idle();
        model_reset();

        // Call in slot 0 from a fresh stack.
        do_reset();
        one_call(0, 80'h1230);
        post();
        chk("s1_ra",       bus.ra,             80'h1235);
        chk("s1_ckpt_ptr", 80'(bus.ckpt_ptr),  80'(0));
        chk("s1_ckpt_top", bus.ckpt_top,       RSTPC);

        // Last slot rolls into the next bundle, then a return empties the stack.
        do_reset();
        one_call(2, 80'hFFF0);
        post();
        chk("s2_ra_last", bus.ra, 80'h10000);
        one_ret(0);
        post();
        chk("s2_ra_ret",  bus.ra,            RSTPC);
        chk("s2_rav_ret", 80'(bus.ra_valid), 80'(0));

        // Call in slot 1 masks a return in slot 2.
        do_reset();
        @(negedge clk);
        idle();
        bus.ip = 80'h40;
        set_slot(1, 1, 0, 0, 7'd0, 7'd0);
        set_slot(2, 0, 1, 0, 7'd0, 7'd0);
        apply();
        post();
        chk("s3_ra",   bus.ra,             80'h4A);
        chk("s3_slot", 80'(bus.ckpt_slot), 80'(1));

        // Fill past capacity, then drain past empty.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            one_call(0, 80'(i) << 8);
            if (i >= 15) begin
                post();
                chk($sformatf("s4_ovf_%0d", i + 1), 80'(bus.overflow), 80'(i == 16));
            end
        end
        for (int i = 0; i < 17; i++) begin
            one_ret(0);
            if (i >= 15) begin
                post();
                chk($sformatf("s4_unf_%0d", i + 1), 80'(bus.underflow), 80'(i == 16));
            end
        end
        chk("s4_rav_empty", 80'(bus.ra_valid), 80'(0));

        // Co-routine JAL swaps the top.
        do_reset();
        one_call(0, 80'h100);
        @(negedge clk);
        idle();
        bus.ip = 80'h200;
        set_slot(0, 0, 0, 1, 7'd61, 7'd61);
        apply();
        post();
        chk("s5_ra",       bus.ra,             80'h205);
        chk("s5_ckpt_cnt", 80'(bus.ckpt_cnt),  80'(1));
        chk("s5_ckpt_ptr", 80'(bus.ckpt_ptr),  80'(15));

        // Checkpoint, three calls, restore racing a call.
        do_reset();
        one_call(0, 80'h300);
        one_call(0, 80'h400);
        ck.ptr = last_e.ptr; ck.cnt = last_e.cnt; ck.top = last_e.top;
        one_call(0, 80'h500);
        one_call(0, 80'h600);
        @(negedge clk);
        idle();
        bus.ip = 80'h700;
        set_slot(0, 1, 0, 0, 7'd0, 7'd0);
        bus.restore     = 1'b1;
        bus.restore_ptr = PW'(ck.ptr);
        bus.restore_cnt = (PW+1)'(ck.cnt);
        bus.restore_top = ck.top;
        apply();
        post();
        chk("s6_ra",   bus.ra,             80'h305);
        chk("s6_rav",  80'(bus.ra_valid),  80'(1));
        chk("s6_vld",  80'(bus.ckpt_vld),  80'(0));
        one_ret(0);
        post();
        chk("s6_ret_rav", 80'(bus.ra_valid), 80'(0));

        // Randomized bundles, with restores from model checkpoints and a
        // mid-run reset.
        do_reset();
        for (int n = 0; n < 2400; n++) begin
            if (n == 1200) do_reset();
            @(negedge clk);
            idle();
            if ($urandom_range(31) == 0) bus.regLR = 6'($urandom);
            else if ($urandom_range(7) == 0) bus.regLR = 6'd61;
            bus.ip = 80'({$urandom, $urandom, $urandom});
            for (int s = 0; s < QS; s++) begin
                int k;
                k = $urandom_range(4);
                bus.queuedOn[s] = ($urandom_range(3) != 0);
                bus.call[s]     = (k == 1);
                bus.ret[s]      = (k == 2);
                bus.jal[s]      = (k == 3);
                bus.Ra[s] = $urandom_range(1) ? {1'b0, bus.regLR} : 7'($urandom);
                bus.Rd[s] = $urandom_range(1) ? {1'b0, bus.regLR} : 7'($urandom);
            end
            if ($urandom_range(19) == 0) begin
                bus.restore = 1'b1;
                if (ck_q.size() > 0) begin
                    ck = ck_q[$urandom_range(ck_q.size() - 1)];
                end else begin
                    ck.ptr = mp; ck.cnt = mc; ck.top = mem[mp];
                end
                bus.restore_ptr = PW'(ck.ptr);
                bus.restore_cnt = (PW+1)'(ck.cnt);
                bus.restore_top = ck.top;
            end
            apply();
        end

        @(negedge clk);
        idle();
        post();
        post();
        chk("sb_drain", 80'(sb.size()), 80'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rsb_ckpt.md
Name: rsb_ckpt

Overview:
- Parametrised return-address stack predictor with checkpoint/restore, updated at fetch time.
- Scans up to QSLOTS queued instructions per cycle. Pushes the return address for calls and link-register JALs, pops for returns, and swaps the top for co-routine JALs.
- Exports a checkpoint with every modifying update, so the commit/branch unit can repair the stack exactly after a misprediction. This replaces pointer-only stomp correction.

Parameters:
- AMSB, 79, MSB of instruction addresses.
- DEPTH, 16, stack entries; power of two, 4..64.
- QSLOTS, 3, instruction slots per 16-byte fetch bundle; 1..3.
- RSTPC, 80'hFFFFFFFFFFFFFFFC0100, reset value of every entry.
- PW, $clog2(DEPTH), pointer width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- regLR  in  6  link register number.
- queuedOn  in  QSLOTS  slot is queued this cycle.
- jal  in  QSLOTS  slot is a JAL.
- call  in  QSLOTS  slot is a CALL.
- ret  in  QSLOTS  slot is a RET.
- Ra  in  7 x QSLOTS  source register per slot.
- Rd  in  7 x QSLOTS  destination register per slot.
- ip  in  AMSB+1  bundle address; ip[3:0] ignored.
- restore  in  1  repair request.
- restore_ptr  in  PW  checkpointed pointer.
- restore_cnt  in  PW+1  checkpointed occupancy.
- restore_top  in  AMSB+1  checkpointed entry at restore_ptr.
- ra  out  AMSB+1  predicted return address, ras[rasp].
- ra_valid  out  1  count != 0.
- ckpt_vld  out  1  a modifying slot was processed this cycle.
- ckpt_slot  out  2  index of that slot.
- ckpt_ptr  out  PW  rasp before the update.
- ckpt_cnt  out  PW+1  count before the update.
- ckpt_top  out  AMSB+1  ras[rasp] before the update.
- overflow  out  1  pulse: push while full.
- underflow  out  1  pulse: pop while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - every ras entry = RSTPC; rasp=0; count=0.
  - ckpt_vld, overflow, underflow = 0; ckpt_slot, ckpt_ptr, ckpt_cnt = 0; ckpt_top = RSTPC.
  - ra=RSTPC; ra_valid=0.
- Slot decode, for slot s:
  - push_s = queuedOn[s] & (call[s] | (jal[s] & Rd[s][5:0]==regLR)).
  - pop_s = queuedOn[s] & (ret[s] | (jal[s] & Ra[s][5:0]==regLR)).
  - mod_s = push_s | pop_s.
- Only the lowest-index slot with mod_s set acts in a cycle. Higher slots are ignored, because fetch redirects on that slot.
- Return address for slot s:
  - s < QSLOTS-1: {ip[AMSB:4], 4'(5*(s+1))}, i.e. 4'h5 or 4'hA.
  - last slot: {ip[AMSB:4]+1, 4'h0}; the carry is discarded at AMSB.
- Update, applied on the next posedge with pointer arithmetic modulo DEPTH:
  - Push only: ras[rasp-1] <= retaddr; rasp <= rasp-1; count <= min(count+1, DEPTH). If count==DEPTH beforehand, pulse overflow; the oldest entry is silently lost.
  - Pop only, count>0: rasp <= rasp+1; count <= count-1.
  - Pop only, count==0: rasp and count unchanged; pulse underflow.
  - Push and pop together (co-routine JAL): ras[rasp] <= retaddr; rasp and count unchanged.
- Checkpoint outputs are registered and valid for exactly one cycle after the acting edge. They hold the pre-update rasp, count, ras[rasp] and the slot index. The overflow and underflow pulses share this timing.
- Restore: rasp <= restore_ptr; count <= restore_cnt; ras[restore_ptr] <= restore_top.
  - Restore has priority; all slot updates in the same cycle are discarded.
  - ckpt_vld, overflow and underflow are 0 on the following cycle.
- ra and ra_valid are combinational from the current state; there is no bypass of the same-cycle update.
- A reset assertion mid-operation aborts everything immediately; all state returns to reset values.

Test Plan:
- Reset, then a call in slot 0 with ip=0x...1230 → next cycle ra=0x...1235, rasp=15, count=1, ckpt_vld=1, ckpt_ptr=0, ckpt_cnt=0, ckpt_top=RSTPC.
- Call in slot 2 (last slot) with ip=0x...FFF0 → ra=0x...10000. Then RET in slot 0 → ra=RSTPC, ra_valid=0.
- Call in slot 1 and ret in slot 2 in the same cycle, ip=0x...40 → only slot 1 acts: ra=0x...4A, ckpt_slot=1.
- 17 consecutive calls → overflow pulses on the 17th only; count=16. Then 17 rets → underflow pulses on the 17th; count=0.
- JAL with Ra=Rd=regLR=61 after one call → top replaced with the new return address; rasp and count unchanged.
- Take a checkpoint, issue 3 calls, then assert restore with the checkpoint values while a call is also presented → that call is ignored; ra equals the checkpointed top; count equals the checkpointed count.
